frame_load_ctrl: RTL and testbench
==================================

FRAME_LOAD_CTRL -- requirements
Module: frame_load_ctrl

Interface
REQ-001 SHALL have parameter MAX_W, default 320, maximum accepted frame width in pixels.
REQ-002 SHALL have parameter MAX_H, default 240, maximum accepted frame height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 17, width of the frame-buffer address; MAX_W*MAX_H fits in ADDR_W bits.
REQ-004 SHALL have parameter TIMEOUT, default 2**20, idle cycles tolerated between pixels mid-frame.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 hdr_valid  input  1  one-cycle strobe: height and width are valid.
REQ-008 height  input  16  frame height from the parser.
REQ-009 width  input  16  frame width from the parser.
REQ-010 pix_valid  input  1  one-cycle strobe: pix_r/g/b are valid.
REQ-011 pix_r, pix_g, pix_b  input  8 each  pixel colour components.
REQ-012 fb_we  output  1  frame-buffer write enable.
REQ-013 fb_addr  output  ADDR_W  frame-buffer write address.
REQ-014 fb_wdata  output  24  packed pixel {r,g,b}.
REQ-015 busy  output  1  high in LOAD and WRITE.
REQ-016 frame_done  output  1  one-cycle pulse after the last pixel is written.
REQ-017 dim_err  output  1  one-cycle pulse on a rejected header.
REQ-018 timeout_err  output  1  one-cycle pulse on a pixel-gap abort.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-020 IDLE: on hdr_valid, latch height/width and go to LOAD; pix_valid is ignored.
REQ-021 LOAD (one cycle): if either latched dimension is 0, or width>MAX_W, or height>MAX_H, pulse dim_err and return to IDLE; otherwise clear col, row and addr to 0 and enter WRITE.
REQ-022 WRITE: each pix_valid writes exactly one pixel; fb_we=1, fb_addr=current addr, fb_wdata={pix_r,pix_g,pix_b} in the cycle after pix_valid (latency 1, registered outputs).
REQ-023 On each accepted pixel: addr increments by 1; col increments; at col==width-1, col wraps to 0 and row increments.
REQ-024 No multiplier SHALL be used; the address is a running counter.
REQ-025 The pixel at col==width-1 and row==height-1 is the last; after accepting it, go to DONE.
REQ-026 DONE (one cycle): frame_done=1; return to IDLE.
REQ-027 hdr_valid in LOAD, WRITE or DONE SHALL be ignored; a frame is never restarted mid-load.
REQ-028 Simultaneous hdr_valid and pix_valid in IDLE: the header is accepted and the pixel is dropped.
REQ-029 WRITE keeps a gap counter, cleared on every pix_valid; on reaching TIMEOUT it pulses timeout_err and returns to IDLE with no further writes.
REQ-030 fb_we SHALL be 0 in every cycle not caused by a WRITE-state pixel.
REQ-031 fb_addr and fb_wdata SHALL hold their last values when fb_we=0.

Reset
REQ-032 On reset=1 at a clock edge: state=IDLE; fb_we, busy, frame_done, dim_err, timeout_err=0; fb_addr=0; fb_wdata=0; col, row and the gap counter=0.
REQ-033 Reset mid-WRITE SHALL abandon the frame with no pulse on frame_done or any error output.

Structure
REQ-034 The FSM state encoding and the 24-bit pixel packing width SHALL be in a shared package, frame_pkg.
REQ-035 The col/row/addr counters SHALL be one sub-module, raster_counter, with inputs clear, step, width, height and outputs addr and last.

Verification
REQ-036 Header 2x3 (h=2, w=3), then 6 pixels -> fb_addr 0..5 with fb_we each, frame_done one cycle after the 6th write, busy low after DONE.
REQ-037 Header w=0 or w=MAX_W+1 -> dim_err pulse 2 cycles after hdr_valid, no fb_we, state IDLE.
REQ-038 Header 1x1, pixel {0x12,0x34,0x56} -> fb_we with fb_addr=0 and fb_wdata=0x123456, then frame_done.
REQ-039 Header 2x2, 2 pixels, then a second hdr_valid, then 2 pixels -> second header ignored, addrs 0..3, single frame_done.
REQ-040 TIMEOUT=16, header 2x2, 1 pixel, then silence -> timeout_err 16 cycles after the last pixel, then IDLE; a later pixel is not written.
REQ-041 Reset asserted after the 3rd pixel of 4x4 -> all outputs 0 the next cycle, no frame_done; a new 1x1 frame then writes fb_addr=0.

Source files
------------

// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
//   Types and constants shared by the frame loader and its raster counter.
//   - frame_state_t : loader FSM state encoding
//   - PIX_W         : width of one packed frame-buffer pixel
//   - pack_rgb()    : packs three 8-bit components into one PIX_W word
// -----------------------------------------------------------------------------
package frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } frame_state_t;

    localparam int PIX_W = 24;

    // Red lands in the top byte so the buffer word reads as 0xRRGGBB.
    function automatic logic [PIX_W-1:0] pack_rgb(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {r, g, b};
    endfunction

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
//   Tracks the column/row position of the next pixel in a frame and the
//   matching linear frame-buffer address. The address is a running counter,
//   so no width*row product is ever formed.
//
// Ports
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   clear   in   return col, row and addr to 0 (start of a frame)
//   step    in   one pixel accepted: advance position by one
//   width   in   [15:0] frame width (non-zero while stepping)
//   height  in   [15:0] frame height (non-zero while stepping)
//   addr    out  [ADDR_W-1:0] address of the pixel at the current position
//   last    out  current position is the final pixel of the frame
// -----------------------------------------------------------------------------
module raster_counter
    import frame_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    input  logic [15:0]       width,
    input  logic [15:0]       height,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [15:0] col;
    logic [15:0] row;
    logic        col_end;
    logic        row_end;

    assign col_end = (col == width  - 16'd1);
    assign row_end = (row == height - 16'd1);
    assign last    = col_end && row_end;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (step) begin
            addr <= addr + ADDR_W'(1);
            if (col_end) begin
                col <= '0;
                row <= row + 16'd1;
            end else begin
                col <= col + 16'd1;
            end
        end
    end

endmodule

// File: rtl/frame_load_ctrl.sv
// -----------------------------------------------------------------------------
// frame_load_ctrl
//   Accepts a frame header (height/width) from an image parser, validates the
//   dimensions, then writes each incoming pixel into a frame buffer at
//   consecutive addresses starting from 0. Reports completion, rejected
//   headers and mid-frame stalls with single-cycle pulses.
//
// Parameters
//   MAX_W, MAX_H  largest accepted frame dimensions
//   ADDR_W        frame-buffer address width (MAX_W*MAX_H must fit)
//   TIMEOUT       idle cycles tolerated between pixels while writing
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   synchronous active-high reset
//   hdr_valid     in   strobe: height/width valid
//   height        in   [15:0] frame height
//   width         in   [15:0] frame width
//   pix_valid     in   strobe: pix_r/g/b valid
//   pix_r/g/b     in   [7:0] pixel components
//   fb_we         out  frame-buffer write enable (one cycle per pixel)
//   fb_addr       out  [ADDR_W-1:0] write address, held while fb_we=0
//   fb_wdata      out  [23:0] packed {r,g,b}, held while fb_we=0
//   busy          out  header being checked or frame being written
//   frame_done    out  pulse after the last pixel's write
//   dim_err       out  pulse when a header is rejected
//   timeout_err   out  pulse when a frame is aborted for a pixel gap
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a header; pixels are dropped
//   ST_LOAD  | one cycle: validate latched dims, reset raster position
//   ST_WRITE | writing pixels; gap counter watches for stalls
//   ST_DONE  | one cycle: frame complete, raise frame_done
// -----------------------------------------------------------------------------
module frame_load_ctrl
    import frame_pkg::*;
#(
    parameter int MAX_W   = 320,
    parameter int MAX_H   = 240,
    parameter int ADDR_W  = 17,
    parameter int TIMEOUT = 2**20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hdr_valid,
    input  logic [15:0]       height,
    input  logic [15:0]       width,
    input  logic              pix_valid,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              dim_err,
    output logic              timeout_err
);

    // One extra count of headroom: the counter still advances on the cycle
    // that triggers the timeout.
    localparam int          GAP_W    = $clog2(TIMEOUT + 1);
    localparam logic [15:0] MAX_W_L  = 16'(MAX_W);
    localparam logic [15:0] MAX_H_L  = 16'(MAX_H);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

    frame_state_t      state;
    frame_state_t      state_nxt;

    logic [15:0]       h_lat;
    logic [15:0]       w_lat;
    logic [GAP_W-1:0]  gap_cnt;

    logic [ADDR_W-1:0] rc_addr;
    logic              rc_last;
    logic              rc_clear;
    logic              rc_step;

    logic              latch_hdr;
    logic              take_pix;
    logic              raise_dim;
    logic              raise_to;
    logic              raise_done;

    logic              dims_bad;
    logic              gap_hit;

    assign dims_bad = (w_lat == 16'd0) || (h_lat == 16'd0) ||
                      (w_lat > MAX_W_L) || (h_lat > MAX_H_L);

    // True on the TIMEOUT-th consecutive WRITE cycle without a pixel.
    assign gap_hit  = (gap_cnt == GAP_LAST);

    assign busy     = (state == ST_LOAD) || (state == ST_WRITE);

    raster_counter #(
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk    (clk),
        .reset  (reset),
        .clear  (rc_clear),
        .step   (rc_step),
        .width  (w_lat),
        .height (h_lat),
        .addr   (rc_addr),
        .last   (rc_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        latch_hdr  = 1'b0;
        rc_clear   = 1'b0;
        rc_step    = 1'b0;
        take_pix   = 1'b0;
        raise_dim  = 1'b0;
        raise_to   = 1'b0;
        raise_done = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // A pixel arriving with the header is dropped: nothing
                // below looks at pix_valid in this state.
                if (hdr_valid) begin
                    latch_hdr = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (dims_bad) begin
                    raise_dim = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    rc_clear  = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (pix_valid) begin
                    take_pix = 1'b1;
                    rc_step  = 1'b1;
                    if (rc_last) begin
                        state_nxt = ST_DONE;
                    end
                end else if (gap_hit) begin
                    raise_to  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                raise_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            frame_done  <= 1'b0;
            dim_err     <= 1'b0;
            timeout_err <= 1'b0;
            h_lat       <= '0;
            w_lat       <= '0;
            gap_cnt     <= '0;
        end else begin
            fb_we       <= take_pix;
            frame_done  <= raise_done;
            dim_err     <= raise_dim;
            timeout_err <= raise_to;

            if (take_pix) begin
                fb_addr  <= rc_addr;
                fb_wdata <= pack_rgb(pix_r, pix_g, pix_b);
            end

            if (latch_hdr) begin
                h_lat <= height;
                w_lat <= width;
            end

            if (state == ST_LOAD || take_pix) begin
                gap_cnt <= '0;
            end else if (state == ST_WRITE) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_load_ctrl
//   Directed stimulus against frame_load_ctrl. A frame-level model (pixel
//   count against width*height, gap count against TIMEOUT) predicts every
//   output each cycle; literal expectations pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_frame_load_ctrl;

    localparam int TB_MAX_W = 320;
    localparam int TB_MAX_H = 240;
    localparam int TB_AW    = 17;
    localparam int TB_TO    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              hdr_valid;
    logic [15:0]       height;
    logic [15:0]       width;
    logic              pix_valid;
    logic [7:0]        pix_r;
    logic [7:0]        pix_g;
    logic [7:0]        pix_b;
    logic              fb_we;
    logic [TB_AW-1:0]  fb_addr;
    logic [23:0]       fb_wdata;
    logic              busy;
    logic              frame_done;
    logic              dim_err;
    logic              timeout_err;

    always #5 clk = ~clk;

    frame_load_ctrl #(
        .MAX_W   (TB_MAX_W),
        .MAX_H   (TB_MAX_H),
        .ADDR_W  (TB_AW),
        .TIMEOUT (TB_TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hdr_valid   (hdr_valid),
        .height      (height),
        .width       (width),
        .pix_valid   (pix_valid),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .busy        (busy),
        .frame_done  (frame_done),
        .dim_err     (dim_err),
        .timeout_err (timeout_err)
    );

    // phase: 0 waiting for header, 1 header under check, 2 taking pixels,
    // 3 frame complete
    typedef struct {
        int          phase;
        int          w;
        int          h;
        int          cnt;
        int          gap;
        bit          we;
        int          addr;
        logic [23:0] wdata;
        bit          done;
        bit          derr;
        bit          terr;
    } mdl_t;

    function automatic mdl_t model_step(input mdl_t s, input bit rst,
                                        input bit hv, input int hh,
                                        input int ww, input bit pv,
                                        input logic [23:0] px);
        mdl_t n;
        n      = s;
        n.we   = 1'b0;
        n.done = 1'b0;
        n.derr = 1'b0;
        n.terr = 1'b0;
        if (rst) begin
            n.phase = 0; n.w = 0; n.h = 0; n.cnt = 0; n.gap = 0;
            n.addr  = 0; n.wdata = '0;
            return n;
        end
        case (s.phase)
            0: if (hv) begin
                n.w = ww; n.h = hh; n.phase = 1;
            end
            1: if (s.w == 0 || s.h == 0 || s.w > TB_MAX_W || s.h > TB_MAX_H) begin
                n.derr = 1'b1; n.phase = 0;
            end else begin
                n.cnt = 0; n.gap = 0; n.phase = 2;
            end
            2: if (pv) begin
                n.we    = 1'b1;
                n.addr  = s.cnt;
                n.wdata = px;
                n.gap   = 0;
                n.cnt   = s.cnt + 1;
                if (n.cnt == s.w * s.h) n.phase = 3;
            end else if (s.gap + 1 >= TB_TO) begin
                n.terr = 1'b1; n.phase = 0;
            end else begin
                n.gap = s.gap + 1;
            end
            3: begin
                n.done = 1'b1; n.phase = 0;
            end
            default: n.phase = 0;
        endcase
        return n;
    endfunction

    mdl_t m;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    int   wr_addr[$];
    int   wr_data[$];
    int   done_n = 0;
    int   derr_n = 0;
    int   terr_n = 0;
    int   done_cyc = -1;
    int   derr_cyc = -1;
    int   terr_cyc = -1;
    int   we_cyc = -1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        m   <= model_step(m, reset, hdr_valid, int'(height), int'(width),
                          pix_valid, {pix_r, pix_g, pix_b});
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("fb_we",       32'(fb_we),       32'(m.we));
            check("fb_addr",     32'(fb_addr),     m.addr);
            check("fb_wdata",    32'(fb_wdata),    32'(m.wdata));
            check("busy",        32'(busy),        32'(m.phase == 1 || m.phase == 2));
            check("frame_done",  32'(frame_done),  32'(m.done));
            check("dim_err",     32'(dim_err),     32'(m.derr));
            check("timeout_err", 32'(timeout_err), 32'(m.terr));
        end
        if (fb_we) begin
            wr_addr.push_back(int'(fb_addr));
            wr_data.push_back(int'(fb_wdata));
            we_cyc <= cyc;
        end
        if (frame_done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (dim_err) begin
            derr_n   <= derr_n + 1;
            derr_cyc <= cyc;
        end
        if (timeout_err) begin
            terr_n   <= terr_n + 1;
            terr_cyc <= cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_hdr(input int h, input int w, output int hc);
        height    = 16'(h);
        width     = 16'(w);
        hdr_valid = 1'b1;
        hc        = cyc;
        tick();
        hdr_valid = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
        pix_r     = r;
        pix_g     = g;
        pix_b     = b;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int hc;
        int b0;
        int d0;
        int e0;
        int t0;
        int wc;

        reset     = 1'b1;
        hdr_valid = 1'b0;
        pix_valid = 1'b0;
        height    = '0;
        width     = '0;
        pix_r     = '0;
        pix_g     = '0;
        pix_b     = '0;
        idle(2);
        chk_en = 1'b1;
        reset  = 1'b0;

        // reset state
        check("rst_fb_we",   32'(fb_we),      0);
        check("rst_fb_addr", 32'(fb_addr),    0);
        check("rst_wdata",   32'(fb_wdata),   0);
        check("rst_busy",    32'(busy),       0);
        check("rst_done",    32'(frame_done), 0);
        idle(2);

        // 2x3 frame, six pixels back to back
        b0 = wr_addr.size(); d0 = done_n;
        send_hdr(2, 3, hc);
        tick();
        for (int i = 0; i < 6; i++) send_pix(8'(i), 8'(i + 16), 8'(8'hA0 + i));
        idle(3);
        check("t1_nwr", wr_addr.size() - b0, 6);
        if (wr_addr.size() - b0 == 6) begin
            for (int i = 0; i < 6; i++) check("t1_addr", wr_addr[b0 + i], i);
            check("t1_wdata2", wr_data[b0 + 2], 32'h0002_12A2);
        end
        check("t1_done_n",   done_n - d0, 1);
        check("t1_done_lat", done_cyc - we_cyc, 1);
        check("t1_busy",     32'(busy), 0);

        // rejected headers: zero width and one past the maximum width
        b0 = wr_addr.size(); e0 = derr_n;
        send_hdr(2, 0, hc);
        idle(3);
        check("t2_w0_lat", derr_cyc - hc, 2);
        send_hdr(2, TB_MAX_W + 1, hc);
        idle(3);
        check("t2_wmax_lat", derr_cyc - hc, 2);
        check("t2_derr_n",   derr_n - e0, 2);
        check("t2_nwr",      wr_addr.size() - b0, 0);
        check("t2_busy",     32'(busy), 0);
        // largest legal frame is accepted
        send_hdr(TB_MAX_H, TB_MAX_W, hc);
        idle(2);
        check("t2_max_busy", 32'(busy), 1);
        check("t2_max_derr", derr_n - e0, 2);
        pulse_reset();
        idle(1);

        // 1x1 frame, pixel 12/34/56
        b0 = wr_addr.size(); d0 = done_n;
        send_hdr(1, 1, hc);
        tick();
        send_pix(8'h12, 8'h34, 8'h56);
        idle(3);
        check("t3_nwr", wr_addr.size() - b0, 1);
        if (wr_addr.size() - b0 == 1) begin
            check("t3_addr",  wr_addr[b0], 0);
            check("t3_wdata", wr_data[b0], 32'h0012_3456);
        end
        check("t3_done_n", done_n - d0, 1);

        // header arriving mid-frame is ignored
        b0 = wr_addr.size(); d0 = done_n; e0 = derr_n;
        send_hdr(2, 2, hc);
        tick();
        send_pix(8'h01, 8'h02, 8'h03);
        send_pix(8'h04, 8'h05, 8'h06);
        send_hdr(5, 5, hc);
        send_pix(8'h07, 8'h08, 8'h09);
        send_pix(8'h0A, 8'h0B, 8'h0C);
        idle(3);
        check("t4_nwr", wr_addr.size() - b0, 4);
        if (wr_addr.size() - b0 == 4) begin
            for (int i = 0; i < 4; i++) check("t4_addr", wr_addr[b0 + i], i);
        end
        check("t4_done_n", done_n - d0, 1);
        check("t4_derr_n", derr_n - e0, 0);
        check("t4_busy",   32'(busy), 0);

        // pixel gap aborts the frame
        b0 = wr_addr.size(); d0 = done_n; t0 = terr_n;
        send_hdr(2, 2, hc);
        tick();
        send_pix(8'hAA, 8'hBB, 8'hCC);
        idle(1);
        wc = we_cyc;
        idle(20);
        check("t5_terr_n",   terr_n - t0, 1);
        check("t5_terr_lat", terr_cyc - wc, TB_TO);
        check("t5_busy",     32'(busy), 0);
        send_pix(8'hDD, 8'hEE, 8'hFF);
        idle(3);
        check("t5_nwr",    wr_addr.size() - b0, 1);
        check("t5_done_n", done_n - d0, 0);

        // reset in the middle of a 4x4 frame
        b0 = wr_addr.size(); d0 = done_n; e0 = derr_n; t0 = terr_n;
        send_hdr(4, 4, hc);
        tick();
        for (int i = 0; i < 3; i++) send_pix(8'(i + 1), 8'h00, 8'hFF);
        pulse_reset();
        check("t6_we",    32'(fb_we),       0);
        check("t6_addr",  32'(fb_addr),     0);
        check("t6_wdata", 32'(fb_wdata),    0);
        check("t6_busy",  32'(busy),        0);
        check("t6_done",  32'(frame_done),  0);
        check("t6_errs",  32'(dim_err | timeout_err), 0);
        idle(3);
        check("t6_done_n", done_n - d0, 0);
        check("t6_err_n",  (derr_n - e0) + (terr_n - t0), 0);
        send_hdr(1, 1, hc);
        tick();
        send_pix(8'h5A, 8'hA5, 8'h3C);
        idle(3);
        check("t6_nwr", wr_addr.size() - b0, 4);
        if (wr_addr.size() - b0 == 4) begin
            check("t6_new_addr",  wr_addr[b0 + 3], 0);
            check("t6_new_wdata", wr_data[b0 + 3], 32'h005A_A53C);
        end
        check("t6_done_new", done_n - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
